tag_refill_ctrl: RTL and testbench

//  Write-side feeder for the free-tag FIFO. After reset it seeds the FIFO with every tag 0..NUM_TAGS-1.
//  It then recycles tags freed at commit, up to two per cycle, into the FIFO write port.

---
 rtl/tag_pkg.sv | 18 +
 rtl/tag_hold_buf.sv | 56 +++++
 rtl/tag_refill_ctrl.sv | 149 ++++++++++++++
 tb/tb_tag_refill_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tag_pkg.sv
// Shared definitions for the free-tag refill path: default sizes, tag type and FSM encoding.
package tag_pkg;

    localparam int DSIZE_DEF      = 5;
    localparam int NUM_TAGS_DEF   = 32;
    localparam int HOLD_DEPTH_DEF = 4;

    typedef logic [DSIZE_DEF-1:0] tag_t;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Occupancy counters need one extra bit so a completely full queue is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tag_hold_buf.sv
// Circular holding queue for released tags: up to two pushes and one pop per cycle.
module tag_hold_buf #(
    parameter int DSIZE      = 5,
    parameter int HOLD_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push0_i,
    input  logic [DSIZE-1:0]              data0_i,
    input  logic                          push1_i,
    input  logic [DSIZE-1:0]              data1_i,
    input  logic                          pop_i,
    output logic [DSIZE-1:0]              head_o,
    output logic [$clog2(HOLD_DEPTH):0]   count_o
);

    localparam int AW = $clog2(HOLD_DEPTH);
    localparam int CW = AW + 1;

    logic [DSIZE-1:0] mem_q [HOLD_DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    wptr_p1;
    logic [CW-1:0]    count_q;
    logic [DSIZE-1:0] first_data;
    logic [1:0]       nenq;

    // A lone slot-1 push still lands at the write pointer so the queue stays dense.
    assign first_data = push0_i ? data0_i : data1_i;
    assign nenq       = {1'b0, push0_i} + {1'b0, push1_i};
    assign wptr_p1    = wptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (push0_i || push1_i) begin
            mem_q[wptr_q] <= first_data;
        end
        if (push0_i && push1_i) begin
            mem_q[wptr_p1] <= data1_i;
        end
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(nenq);
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_q + CW'(nenq) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tag_refill_ctrl.sv
// Free-tag FIFO write-side feeder: seeds every tag after reset, then recycles released tags.
// Optional duplicate-release checker enabled by defining TAG_REFILL_CHK_EN.
module tag_refill_ctrl
    import tag_pkg::*;
#(
    parameter int DSIZE      = DSIZE_DEF,
    parameter int NUM_TAGS   = NUM_TAGS_DEF,
    parameter int HOLD_DEPTH = HOLD_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_wfull,
    output logic             fifo_winc,
    output logic [DSIZE-1:0] fifo_wdata,
    input  logic             ret0_valid,
    input  logic [DSIZE-1:0] ret0_tag,
    input  logic             ret1_valid,
    input  logic [DSIZE-1:0] ret1_tag,
    output logic             ret_ready,
    output logic             init_done,
    input  logic             alloc_valid,
    input  logic [DSIZE-1:0] alloc_tag,
    output logic             dup_err
);

    localparam int              CW        = cnt_width(HOLD_DEPTH);
    localparam logic [CW-1:0]   READY_MAX = CW'(HOLD_DEPTH - 2);
    localparam logic [DSIZE-1:0] LAST_TAG = DSIZE'(NUM_TAGS - 1);

    logic [0:0]       state_q, state_d;
    logic [DSIZE-1:0] init_cnt_q, init_cnt_d;
    logic             init_done_q, init_done_d;
    logic [CW-1:0]    count;
    logic [DSIZE-1:0] head;
    logic             seed_wr, pop, acc0, acc1, enq0, enq1, seed_last;

    // Readiness depends only on registered occupancy, never on fifo_wfull.
    assign ret_ready  = rst_n && (state_q == ST_RUN) && (count <= READY_MAX);
    assign acc0       = ret_ready && ret0_valid;
    assign acc1       = ret_ready && ret1_valid;
    assign seed_wr    = rst_n && (state_q == ST_INIT) && !fifo_wfull;
    assign seed_last  = seed_wr && (init_cnt_q == LAST_TAG);
    assign pop        = rst_n && (state_q == ST_RUN) && (count != '0) && !fifo_wfull;
    assign fifo_winc  = seed_wr || pop;
    assign fifo_wdata = (state_q == ST_INIT) ? init_cnt_q : head;
    assign init_done  = init_done_q;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (seed_wr) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
        if (seed_last) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef TAG_REFILL_CHK_EN
    logic [NUM_TAGS-1:0] free_q, free_d;
    logic                dup_q, dup_d;

    function automatic logic [NUM_TAGS-1:0] tag_bit(input logic [DSIZE-1:0] t);
        tag_bit = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (t == DSIZE'(i)) begin
                tag_bit[i] = 1'b1;
            end
        end
    endfunction

    // Alloc clear goes first so a same-cycle alloc+release of one tag is legal.
    always_comb begin
        free_d = free_q;
        enq0   = acc0;
        enq1   = acc1;
        dup_d  = 1'b0;
        if (state_q == ST_RUN) begin
            if (alloc_valid) begin
                free_d = free_d & ~tag_bit(alloc_tag);
            end
            if (acc0 && ((free_d & tag_bit(ret0_tag)) != '0)) begin
                enq0  = 1'b0;
                dup_d = 1'b1;
            end
            if (enq0) begin
                free_d = free_d | tag_bit(ret0_tag);
            end
            if (acc1 && (((free_d & tag_bit(ret1_tag)) != '0) || (acc0 && (ret0_tag == ret1_tag)))) begin
                enq1  = 1'b0;
                dup_d = 1'b1;
            end
            if (enq1) begin
                free_d = free_d | tag_bit(ret1_tag);
            end
        end else if (seed_last) begin
            free_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_q <= '0;
            dup_q  <= 1'b0;
        end else begin
            free_q <= free_d;
            dup_q  <= dup_d;
        end
    end

    assign dup_err = dup_q && rst_n;
`else
    logic unused_alloc;
    assign unused_alloc = ^{alloc_valid, alloc_tag};
    assign enq0         = acc0;
    assign enq1         = acc1;
    assign dup_err      = 1'b0;
`endif

    tag_hold_buf #(
        .DSIZE      (DSIZE),
        .HOLD_DEPTH (HOLD_DEPTH)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .push0_i (enq0),
        .data0_i (ret0_tag),
        .push1_i (enq1),
        .data1_i (ret1_tag),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_tag_refill_ctrl.sv
// Scoreboard bench for tag_refill_ctrl; define TAG_REFILL_CHK_EN to also exercise the duplicate checker.
module tb_tag_refill_ctrl;
    import tag_pkg::*;

    localparam int NUM_TAGS   = 32;
    localparam int HOLD_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n, fifo_wfull, fifo_winc, ret0_valid, ret1_valid;
    logic ret_ready, init_done, alloc_valid, dup_err;
    tag_t fifo_wdata, ret0_tag, ret1_tag, alloc_tag;

    tag_t expQ[$];
    bit   expDone = 1'b0;
    bit   expDup = 1'b0;
    int   seedLeft = 0;
    int   checks = 0;
    int   errors = 0;
`ifdef TAG_REFILL_CHK_EN
    bit   freeSet[NUM_TAGS];
`endif

    always #5 clk = ~clk;

    tag_refill_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_wfull  (fifo_wfull),
        .fifo_winc   (fifo_winc),
        .fifo_wdata  (fifo_wdata),
        .ret0_valid  (ret0_valid),
        .ret0_tag    (ret0_tag),
        .ret1_valid  (ret1_valid),
        .ret1_tag    (ret1_tag),
        .ret_ready   (ret_ready),
        .init_done   (init_done),
        .alloc_valid (alloc_valid),
        .alloc_tag   (alloc_tag),
        .dup_err     (dup_err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // After reset the FIFO must see every tag in order, then only released tags in arrival order.
    task automatic resetModel();
        expQ.delete();
        for (int i = 0; i < NUM_TAGS; i++) begin
            expQ.push_back(tag_t'(i));
        end
        expDone  = 1'b0;
        expDup   = 1'b0;
        seedLeft = NUM_TAGS;
`ifdef TAG_REFILL_CHK_EN
        foreach (freeSet[i]) freeSet[i] = 1'b0;
`endif
    endtask

    // Drives one cycle of inputs shortly after a rising edge and updates the model at the next edge.
    task automatic applyStimulus(input int v0, input int t0, input int v1, input int t1,
                                 input int full, input int av, input int at, input int rstn);
        bit rdy, a0, a1, e0, e1, d;
        rst_n       = (rstn != 0);
        fifo_wfull  = (full != 0);
        ret0_valid  = (v0 != 0);
        ret0_tag    = tag_t'(t0);
        ret1_valid  = (v1 != 0);
        ret1_tag    = tag_t'(t1);
        alloc_valid = (av != 0);
        alloc_tag   = tag_t'(at);
        rdy = (rstn != 0) && expDone && (expQ.size() <= HOLD_DEPTH - 2);
        a0  = rdy && (v0 != 0);
        a1  = rdy && (v1 != 0);
        e0  = a0;
        e1  = a1;
        d   = 1'b0;
`ifdef TAG_REFILL_CHK_EN
        if ((rstn != 0) && expDone && (av != 0)) freeSet[at] = 1'b0;
        if (a0 && freeSet[t0]) begin
            e0 = 1'b0;
            d  = 1'b1;
        end
        if (e0) freeSet[t0] = 1'b1;
        if (a1 && (freeSet[t1] || (a0 && (t0 == t1)))) begin
            e1 = 1'b0;
            d  = 1'b1;
        end
        if (e1) freeSet[t1] = 1'b1;
`endif
        @(posedge clk);
        if (rstn == 0) begin
            resetModel();
        end else begin
            if (e0) expQ.push_back(tag_t'(t0));
            if (e1) expQ.push_back(tag_t'(t1));
            expDup = d;
        end
        #1;
    endtask

    task automatic stepIdle(input int full);
        applyStimulus(0, 0, 0, 0, full, 0, 0, 1);
    endtask

    // Monitor: samples on the falling edge and pops the scoreboard on every FIFO write.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_winc", int'(fifo_winc), 0);
                checkOutput("rst_ready", int'(ret_ready), 0);
                checkOutput("rst_dup", int'(dup_err), 0);
            end else begin
                bit expWinc;
                checkOutput("init_done", int'(init_done), int'(expDone));
                checkOutput("ret_ready", int'(ret_ready),
                            int'(expDone && (expQ.size() <= HOLD_DEPTH - 2)));
                checkOutput("dup_err", int'(dup_err), int'(expDup));
                expWinc = !fifo_wfull && (expQ.size() != 0);
                checkOutput("fifo_winc", int'(fifo_winc), int'(expWinc));
                if (expWinc && fifo_winc) begin
                    checkOutput("fifo_wdata", int'(fifo_wdata), int'(expQ[0]));
                    void'(expQ.pop_front());
                    if (!expDone) begin
                        seedLeft--;
                        if (seedLeft == 0) begin
                            expDone = 1'b1;
`ifdef TAG_REFILL_CHK_EN
                            foreach (freeSet[i]) freeSet[i] = 1'b1;
`endif
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        fifo_wfull  = 1'b0;
        ret0_valid  = 1'b0;
        ret0_tag    = '0;
        ret1_valid  = 1'b0;
        ret1_tag    = '0;
        alloc_valid = 1'b0;
        alloc_tag   = '0;
        resetModel();
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] seeding with FIFO never full");
        repeat (36) stepIdle(0);

        $display("[TB] two releases in one cycle");
        applyStimulus(1, 7, 1, 12, 0, 0, 0, 1);
        repeat (4) stepIdle(0);

        $display("[TB] hold queue saturates while FIFO is full");
        applyStimulus(1, 1, 1, 2, 1, 0, 0, 1);
        applyStimulus(1, 3, 1, 4, 1, 0, 0, 1);
        applyStimulus(1, 5, 1, 6, 1, 0, 0, 1);
        stepIdle(1);
        repeat (6) stepIdle(0);

        $display("[TB] reset mid-run with three queued tags, then seeding with a full stall");
        applyStimulus(1, 8, 1, 9, 1, 0, 0, 1);
        applyStimulus(1, 10, 0, 0, 1, 0, 0, 1);
        stepIdle(1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        for (int c = 1; c <= 40; c++) begin
            stepIdle(int'(c >= 5 && c <= 7));
        end

`ifdef TAG_REFILL_CHK_EN
        $display("[TB] duplicate releases");
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 4, 1);
        applyStimulus(1, 4, 1, 4, 0, 0, 0, 1);
        applyStimulus(1, 20, 0, 0, 0, 1, 20, 1);
        repeat (4) stepIdle(0);
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 800; n++) begin
            applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, NUM_TAGS - 1)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, NUM_TAGS - 1)),
                          int'($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, NUM_TAGS - 1)),
                          int'($urandom_range(0, 299) != 0));
        end

        for (int i = 0; i < 100 && !(expDone && expQ.size() == 0); i++) begin
            stepIdle(0);
        end
        checks++;
        if (!(expDone && expQ.size() == 0)) begin
            errors++;
            $display("[TB] FAIL drain: %0d tags still expected, init_done model %0d", expQ.size(), expDone);
        end
        repeat (3) stepIdle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
